wb_slave_router: RTL and testbench
==================================

Name: wb_slave_router

Overview:
- Registered Wishbone router between the Caravel management bus and the user-area slaves (neuromorphic macro wrapper at 0x3000_0000, matrix multiplier at 0x3100_0000).
- Decodes each classic-cycle request and forwards it to exactly one slave.
- Returns that slave's data and ack to the master.
- Terminates unmapped or hung accesses with an error word, so the CPU never stalls.
- Keeps a saturating error counter and the last faulting address for firmware debug.

Parameters:
- S0_BASE, 32'h3000_0000, slave 0 (neuromorphic) base address.
- S1_BASE, 32'h3100_0000, slave 1 (matrix multiplier) base address.
- REGION_MASK, 32'hFFFF_F000, mask applied before base compare (4 KB windows).
- TIMEOUT_CYCLES, 64, maximum BUSY cycles to wait for a slave ack (legal range 2..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on an error termination.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master request
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  master address / write data
- wbs_ack_o  out  1  single-cycle ack to master
- wbs_dat_o  out  32  read data to master
- s0_cyc_o, s0_stb_o, s0_we_o  out  1 each  slave 0 request
- s0_sel_o  out  4  slave 0 byte selects
- s0_adr_o, s0_dat_o  out  32 each  slave 0 address / write data
- s0_dat_i  in  32  slave 0 read data
- s0_ack_i  in  1  slave 0 ack
- s1_*  same set as s0_*  slave 1
- err_pulse_o  out  1  one-cycle pulse per error termination
- err_count_o  out  8  saturating error count
- err_adr_o  out  32  address of most recent error

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE.
  - All s*_cyc/stb/we = 0.
  - All s*_sel/adr/dat outputs = 0.
  - wbs_ack_o = 0, wbs_dat_o = 0.
  - err_pulse_o = 0, err_count_o = 0, err_adr_o = 0.
  - Reset mid-transaction aborts it with no ack.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i at edge T, register adr, dat, we and sel.
  - Decode: hit0 = (adr & REGION_MASK) == S0_BASE; hit1 likewise for S1_BASE.
  - Hit -> BUSY and clear timeout counter.
  - Miss -> RESP with error (wbs_dat_o = ERR_DATA, err_pulse_o = 1, err_count_o += 1 saturating at 255, err_adr_o = adr).
  - Writes to unmapped addresses are acked and discarded.
- BUSY:
  - The selected slave's cyc/stb/we/sel/adr/dat outputs are driven from registers; the other slave's cyc/stb stay 0.
  - On the selected s*_ack_i: capture s*_dat_i into wbs_dat_o, go to RESP. Slave stb drops in the next cycle.
  - No ack: increment counter.
  - When the counter equals TIMEOUT_CYCLES-1 with no ack: error termination (same effects as a miss), go to RESP.
  - Ack in the same cycle as timeout: ack wins, no error.
  - wbs_cyc_i deasserted while BUSY (master abort): slave signals drop next cycle, go to IDLE, no ack, no error.
- RESP:
  - wbs_ack_o = 1 for exactly one cycle, then IDLE.
  - Acks from either slave while in RESP or IDLE are ignored.
  - Acks from the non-selected slave in BUSY are ignored.
- Latency:
  - Request at T, slave ack in first BUSY cycle: wbs_ack_o at T+2.
  - Unmapped address: ack at T+1.
  - Timeout: ack at T+TIMEOUT_CYCLES+1.
- wbs_dat_o holds its last value between acks and is valid only with wbs_ack_o.
  - Write data returned to the master is don't-care; the design drives 0 on a successful write ack.
- Master rule: stb must be dropped in the cycle after ack (classic cycle). Back-to-back requests restart from IDLE with a minimum 1-cycle gap.
- err_pulse_o is asserted in the same cycle the FSM enters RESP with an error and lasts exactly one cycle.

Test Plan:
- Read 0x3000_0010, s0 acks one cycle after stb with 0x1234_5678 -> wbs_ack_o at T+2, wbs_dat_o = 0x1234_5678, s1_cyc_o stays 0, err_count_o = 0.
- Write 0x3100_0004 data 0xA5A5_0001 sel 4'b0011 -> s1_adr_o = 0x3100_0004, s1_dat_o = 0xA5A5_0001, s1_sel_o = 3, s1_we_o = 1; one ack to master; s0 untouched.
- Read 0x3200_0000 (unmapped) -> ack at T+1, wbs_dat_o = 0xDEAD_BEEF, err_pulse_o one cycle, err_count_o = 1, err_adr_o = 0x3200_0000.
- TIMEOUT_CYCLES = 8, s0 never acks -> ack at T+9 with 0xDEAD_BEEF, error counted; repeat with ack on exactly the 8th BUSY cycle -> slave data returned, no error.
- Master drops cyc on the 3rd BUSY cycle -> s0_cyc_o = 0 next cycle, no wbs_ack_o, no error. Then assert wb_rst_i mid-BUSY -> all outputs 0 immediately, FSM IDLE.
- 300 unmapped accesses -> err_count_o saturates at 255; a late duplicate s0_ack_i in IDLE produces no wbs_ack_o.

Source files
------------

// File: rtl/wb_slave_router.sv
// Registered Wishbone router from the Caravel management bus to two user-area slaves.
// Unmapped or hung accesses end with an error word, and firmware can read an error count and address.
module wb_slave_router #(
  parameter logic [31:0] S0_BASE        = 32'h3000_0000,
  parameter logic [31:0] S1_BASE        = 32'h3100_0000,
  parameter logic [31:0] REGION_MASK    = 32'hFFFF_F000,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        s0_cyc_o,
  output logic        s0_stb_o,
  output logic        s0_we_o,
  output logic [3:0]  s0_sel_o,
  output logic [31:0] s0_adr_o,
  output logic [31:0] s0_dat_o,
  input  logic [31:0] s0_dat_i,
  input  logic        s0_ack_i,
  output logic        s1_cyc_o,
  output logic        s1_stb_o,
  output logic        s1_we_o,
  output logic [3:0]  s1_sel_o,
  output logic [31:0] s1_adr_o,
  output logic [31:0] s1_dat_o,
  input  logic [31:0] s1_dat_i,
  input  logic        s1_ack_i,
  output logic        err_pulse_o,
  output logic [7:0]  err_count_o,
  output logic [31:0] err_adr_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] adr_reg, dat_reg, rdata_reg, err_adr_reg;
  logic [3:0]  sel_reg;
  logic        we_reg, tgt_reg, err_pulse_reg;
  logic [7:0]  cnt_reg, err_count_reg;

  logic hit0, hit1, req, sel_ack, timeout, err_event, slave_done;
  logic busy0, busy1;

  assign req     = wbs_cyc_i && wbs_stb_i;
  assign hit0    = (wbs_adr_i & REGION_MASK) == S0_BASE;
  assign hit1    = (wbs_adr_i & REGION_MASK) == S1_BASE;
  assign sel_ack = tgt_reg ? s1_ack_i : s0_ack_i;
  assign timeout = cnt_reg == LAST_WAIT;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Master abort outranks a same-cycle ack; a slave ack outranks the timeout.
  always_comb begin
    state_next = state_reg;
    err_event  = 1'b0;
    slave_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (hit0 || hit1) begin
            state_next = BUSY;
          end else begin
            state_next = RESP;
            err_event  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!wbs_cyc_i) begin
          state_next = IDLE;
        end else if (sel_ack) begin
          state_next = RESP;
          slave_done = 1'b1;
        end else if (timeout) begin
          state_next = RESP;
          err_event  = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy0 = (state_reg == BUSY) && !tgt_reg;
  assign busy1 = (state_reg == BUSY) &&  tgt_reg;

  always_comb begin
    s0_cyc_o    = busy0;
    s0_stb_o    = busy0;
    s0_we_o     = busy0 && we_reg;
    s0_sel_o    = busy0 ? sel_reg : 4'd0;
    s0_adr_o    = busy0 ? adr_reg : 32'd0;
    s0_dat_o    = busy0 ? dat_reg : 32'd0;
    s1_cyc_o    = busy1;
    s1_stb_o    = busy1;
    s1_we_o     = busy1 && we_reg;
    s1_sel_o    = busy1 ? sel_reg : 4'd0;
    s1_adr_o    = busy1 ? adr_reg : 32'd0;
    s1_dat_o    = busy1 ? dat_reg : 32'd0;
    wbs_ack_o   = state_reg == RESP;
    wbs_dat_o   = rdata_reg;
    err_pulse_o = err_pulse_reg;
    err_count_o = err_count_reg;
    err_adr_o   = err_adr_reg;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      adr_reg       <= 32'd0;
      dat_reg       <= 32'd0;
      sel_reg       <= 4'd0;
      we_reg        <= 1'b0;
      tgt_reg       <= 1'b0;
      cnt_reg       <= 8'd0;
      rdata_reg     <= 32'd0;
      err_pulse_reg <= 1'b0;
      err_count_reg <= 8'd0;
      err_adr_reg   <= 32'd0;
    end else begin
      err_pulse_reg <= err_event;
      if (state_reg == IDLE && req) begin
        adr_reg <= wbs_adr_i;
        dat_reg <= wbs_dat_i;
        sel_reg <= wbs_sel_i;
        we_reg  <= wbs_we_i;
        tgt_reg <= hit1 && !hit0;
      end
      // Counts completed BUSY cycles; zero on the first BUSY cycle.
      if (state_reg == BUSY) cnt_reg <= cnt_reg + 8'd1;
      else                   cnt_reg <= 8'd0;
      if (slave_done) begin
        rdata_reg <= we_reg ? 32'd0 : (tgt_reg ? s1_dat_i : s0_dat_i);
      end else if (err_event) begin
        rdata_reg <= ERR_DATA;
      end
      if (err_event) begin
        err_count_reg <= (err_count_reg == 8'hFF) ? 8'hFF : err_count_reg + 8'd1;
        err_adr_reg   <= (state_reg == IDLE) ? wbs_adr_i : adr_reg;
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_router.sv
// Self-checking bench for wb_slave_router: directed vector table, random traffic against
// a latency/result model, and hand-written abort, reset, saturation and stray-ack sequences.
module tb_wb_slave_router;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        s0_cyc, s0_stb, s0_we, s0_ack;
  logic [3:0]  s0_sel;
  logic [31:0] s0_adr, s0_wdat, s0_rdat;
  logic        s1_cyc, s1_stb, s1_we, s1_ack;
  logic [3:0]  s1_sel;
  logic [31:0] s1_adr, s1_wdat, s1_rdat;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [31:0] err_adr;

  int          total = 0;
  int          bad = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_eadr = 32'd0;

  always #5 clk = ~clk;

  wb_slave_router #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .s0_cyc_o(s0_cyc), .s0_stb_o(s0_stb), .s0_we_o(s0_we), .s0_sel_o(s0_sel),
    .s0_adr_o(s0_adr), .s0_dat_o(s0_wdat), .s0_dat_i(s0_rdat), .s0_ack_i(s0_ack),
    .s1_cyc_o(s1_cyc), .s1_stb_o(s1_stb), .s1_we_o(s1_we), .s1_sel_o(s1_sel),
    .s1_adr_o(s1_adr), .s1_dat_o(s1_wdat), .s1_dat_i(s1_rdat), .s1_ack_i(s1_ack),
    .err_pulse_o(err_pulse), .err_count_o(err_count), .err_adr_o(err_adr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: outcome of one classic cycle from the address map, slave ack time and timeout.
  function automatic void ref_xfer(input logic [31:0] a, input logic w, input int ack_at,
                                   input logic [31:0] sd, output int lat,
                                   output logic [31:0] d, output logic err);
    logic [31:0] win;
    win = a & 32'hFFFF_F000;
    if (win != 32'h3000_0000 && win != 32'h3100_0000) begin
      lat = 1; d = 32'hDEAD_BEEF; err = 1'b1;
    end else if (ack_at >= 1 && ack_at <= TO) begin
      lat = ack_at + 1; d = w ? 32'd0 : sd; err = 1'b0;
    end else begin
      lat = TO + 1; d = 32'hDEAD_BEEF; err = 1'b1;
    end
  endfunction

  // ack_at: BUSY cycle (1-based) in which the addressed slave acks; noise: other slave acks every cycle.
  task automatic run_xfer(input string tag, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s, input int ack_at,
                          input logic [31:0] sd, input logic noise, input int exp_lat,
                          input logic [31:0] exp_d, input logic exp_err);
    int          lat;
    int          pulses;
    logic [31:0] got;
    logic        m0, m1, done;
    m0 = (a & 32'hFFFF_F000) == 32'h3000_0000;
    m1 = (a & 32'hFFFF_F000) == 32'h3100_0000;
    adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    s0_rdat = sd; s1_rdat = sd; s0_ack = 1'b0; s1_ack = 1'b0;
    lat = 0; pulses = 0; got = 32'd0; done = 1'b0;
    tick();
    for (int k = 0; k < 300 && !done; k++) begin
      if (err_pulse) pulses++;
      if (k == 0 && m0) begin
        chk({tag, "_s0_ctl"}, {s0_cyc, s0_stb, s0_we, s0_sel}, {1'b1, 1'b1, w, s});
        chk({tag, "_s0_adr"}, s0_adr, a);
        chk({tag, "_s0_dat"}, s0_wdat, d);
        chk({tag, "_s1_idle"}, {s1_cyc, s1_stb}, 2'b00);
      end
      if (k == 0 && m1) begin
        chk({tag, "_s1_ctl"}, {s1_cyc, s1_stb, s1_we, s1_sel}, {1'b1, 1'b1, w, s});
        chk({tag, "_s1_adr"}, s1_adr, a);
        chk({tag, "_s1_dat"}, s1_wdat, d);
        chk({tag, "_s0_idle"}, {s0_cyc, s0_stb}, 2'b00);
      end
      if (ack) begin
        lat = k + 1;
        got = rdat;
        done = 1'b1;
      end else begin
        s0_ack = 1'b0; s1_ack = 1'b0;
        if (ack_at - 1 == k) begin
          if (m1) s1_ack = 1'b1; else s0_ack = 1'b1;
        end
        if (noise) begin
          if (m1) s0_ack = 1'b1; else s1_ack = 1'b1;
        end
        tick();
      end
    end
    cyc = 1'b0; stb = 1'b0; s0_ack = 1'b0; s1_ack = 1'b0;
    if (!done) chk({tag, "_ack_wait"}, 32'd0, 32'd1);
    tick();
    chk({tag, "_ack_once"}, {31'd0, ack}, 32'd0);
    chk({tag, "_pulse_once"}, {31'd0, err_pulse}, 32'd0);
    if (exp_err) begin
      exp_cnt  = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      exp_eadr = a;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, got, exp_d);
    chk({tag, "_pulses"}, pulses, {31'd0, exp_err});
    chk({tag, "_err_count"}, {24'd0, err_count}, exp_cnt);
    chk({tag, "_err_adr"}, err_adr, exp_eadr);
    $display("xfer %s adr=%h we=%0d lat=%0d rdata=%h err_count=%0d", tag, a, w, lat, got, err_count);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;
    logic [31:0] sdat;
    int          lat;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vt[8];

  initial begin
    int          lat;
    logic [31:0] d;
    logic        e;
    logic [31:0] a;
    int          any_ack;

    vt[0] = '{32'h3000_0010, 1'b0, 32'h0,         4'hF, 1,    32'h1234_5678, 2, 32'h1234_5678, 1'b0};
    vt[1] = '{32'h3100_0004, 1'b1, 32'hA5A5_0001, 4'h3, 1,    32'h7777_7777, 2, 32'h0,         1'b0};
    vt[2] = '{32'h3200_0000, 1'b0, 32'h0,         4'hF, 1,    32'h1111_1111, 1, 32'hDEAD_BEEF, 1'b1};
    vt[3] = '{32'h3000_0000, 1'b0, 32'h0,         4'hF, 1000, 32'h2222_2222, 9, 32'hDEAD_BEEF, 1'b1};
    vt[4] = '{32'h3000_0FFC, 1'b0, 32'h0,         4'hF, 8,    32'hCAFE_0001, 9, 32'hCAFE_0001, 1'b0};
    vt[5] = '{32'h3100_0FFC, 1'b0, 32'h0,         4'h1, 9,    32'h3333_3333, 9, 32'hDEAD_BEEF, 1'b1};
    vt[6] = '{32'h3000_1000, 1'b1, 32'h5555_0000, 4'hF, 1,    32'h4444_4444, 1, 32'hDEAD_BEEF, 1'b1};
    vt[7] = '{32'h3100_0100, 1'b0, 32'h0,         4'hC, 3,    32'h0BAD_F00D, 4, 32'h0BAD_F00D, 1'b0};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; adr = 32'd0; wdat = 32'd0;
    s0_ack = 1'b0; s1_ack = 1'b0; s0_rdat = 32'd0; s1_rdat = 32'd0;
    repeat (3) tick();
    chk("reset_ctl", {s0_cyc, s0_stb, s0_we, s1_cyc, s1_stb, s1_we, ack, err_pulse}, 8'd0);
    chk("reset_slave_bus", s0_adr | s0_wdat | s1_adr | s1_wdat | {24'd0, s0_sel, s1_sel}, 32'd0);
    chk("reset_master_bus", rdat, 32'd0);
    chk("reset_err", {24'd0, err_count} | err_adr, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_xfer($sformatf("vec%0d", i), vt[i].adr, vt[i].we, vt[i].dat, vt[i].sel, vt[i].ack_at,
               vt[i].sdat, i[0], vt[i].lat, vt[i].rd, vt[i].err);
      tick();
    end

    for (int i = 0; i < 40; i++) begin
      int          r;
      int          ack_at;
      logic        w;
      logic [31:0] sd;
      r = $urandom_range(0, 2);
      case (r)
        0:       a = 32'h3000_0000 | ($urandom & 32'h0000_0FFC);
        1:       a = 32'h3100_0000 | ($urandom & 32'h0000_0FFC);
        default: a = 32'h3000_1000 + ($urandom & 32'h00FF_FFFC);
      endcase
      w = 1'($urandom_range(0, 1));
      ack_at = $urandom_range(1, TO + 2);
      sd = $urandom;
      ref_xfer(a, w, ack_at, sd, lat, d, e);
      run_xfer($sformatf("rnd%0d", i), a, w, $urandom, 4'($urandom), ack_at, sd,
               1'($urandom_range(0, 1)), lat, d, e);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Master abort on the third BUSY cycle.
    adr = 32'h3000_0020; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    tick(); tick(); tick();
    chk("abort_busy_cyc", {31'd0, s0_cyc}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk("abort_s0_drop", {s0_cyc, s0_stb, ack, err_pulse}, 4'd0);
    any_ack = 0;
    repeat (TO + 4) begin
      tick();
      if (ack || err_pulse) any_ack++;
    end
    chk("abort_no_ack", any_ack, 0);
    chk("abort_err_count", {24'd0, err_count}, exp_cnt);
    $display("xfer abort adr=%h err_count=%0d", adr, err_count);

    // Asynchronous reset in the middle of a slave 1 access.
    adr = 32'h3100_0040; we = 1'b1; wdat = 32'hFEED_0001; cyc = 1'b1; stb = 1'b1;
    tick(); tick();
    chk("rst_pre_busy", {31'd0, s1_cyc}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_ctl", {s1_cyc, s1_stb, s1_we, ack, err_pulse}, 5'd0);
    chk("rst_async_bus", s1_adr | s1_wdat | rdat, 32'd0);
    chk("rst_async_err", {24'd0, err_count} | err_adr, 32'd0);
    cyc = 1'b0; stb = 1'b0; exp_cnt = 0; exp_eadr = 32'd0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_after_ack", {31'd0, ack}, 32'd0);
    $display("xfer reset_mid_busy adr=%h", adr);

    // Counter saturation over 300 unmapped accesses.
    for (int i = 0; i < 300; i++) begin
      a = 32'h3200_0000 | ($urandom & 32'h00FF_FFFC);
      ref_xfer(a, 1'b0, 1, 32'd0, lat, d, e);
      run_xfer($sformatf("sat%0d", i), a, 1'b0, 32'd0, 4'hF, 1, 32'd0, 1'b0, lat, d, e);
    end
    chk("sat_final", {24'd0, err_count}, 32'd255);

    // A late duplicate slave ack while idle must not reach the master.
    run_xfer("late_read", 32'h3000_0008, 1'b0, 32'd0, 4'hF, 1, 32'h600D_DA7A, 1'b0,
             2, 32'h600D_DA7A, 1'b0);
    any_ack = 0;
    s0_ack = 1'b1; s1_ack = 1'b1;
    repeat (4) begin
      tick();
      if (ack || err_pulse) any_ack++;
    end
    s0_ack = 1'b0; s1_ack = 1'b0;
    chk("late_ack_ignored", any_ack, 0);
    chk("late_ack_rdata_held", rdat, 32'h600D_DA7A);
    $display("xfer late_ack stray_acks=%0d", any_ack);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
